// File: rtl/mathrix_pkg.sv
// Shared types and defaults for the equation scheduler and its round timer.
package mathrix_pkg;

    localparam int         NUM_EQ_DEFAULT     = 4;
    localparam logic [6:0] TIME_LIMIT_DEFAULT = 7'd30;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_ANS = 3'd2,
        S_PASS     = 3'd3,
        S_ABORT    = 3'd4,
        S_NEXT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/round_timer.sv
// Captures the start time of the active equation and flags when its answer
// budget has been used up, tolerating one wrap of the 7-bit time count.
module round_timer
    import mathrix_pkg::*;
#(
    parameter logic [6:0] TIME_LIMIT = TIME_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       latch,
    input  logic [6:0] now,
    output logic       timeout
);

    logic [6:0] start_time_q, start_time_d;
    logic [6:0] elapsed;

    always_comb begin
        start_time_d = start_time_q;
        if (latch) begin
            start_time_d = now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_time_q <= 7'd0;
        end else begin
            start_time_q <= start_time_d;
        end
    end

    // 7-bit subtraction is modulo 128, so a single wrap of `now` is harmless.
    assign elapsed = now - start_time_q;
    assign timeout = (elapsed >= TIME_LIMIT);

endmodule

// File: rtl/equation_scheduler.sv
// Sequences NUM_EQ equation blocks through one game: start each, route Go to
// it, and either count a correct answer or abort it on timeout.
module equation_scheduler
    import mathrix_pkg::*;
#(
    parameter int         NUM_EQ     = NUM_EQ_DEFAULT,
    parameter logic [6:0] TIME_LIMIT = TIME_LIMIT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              StartGame,
    input  logic              Go,
    input  logic [6:0]        OngoingTimer,
    input  logic [NUM_EQ-1:0] eq_correct,
    output logic [NUM_EQ-1:0] eq_start,
    output logic [NUM_EQ-1:0] eq_go,
    output logic [NUM_EQ-1:0] eq_abort,
    output logic [2:0]        active_eq,
    output logic [3:0]        score,
    output logic              busy,
    output logic              game_over,
    output state_t            dbg_state
);

    localparam logic [2:0]        LAST_EQ   = 3'(NUM_EQ - 1);
    localparam logic [3:0]        SCORE_MAX = 4'(NUM_EQ);
    localparam logic [NUM_EQ-1:0] ONE       = {{(NUM_EQ-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [2:0]        active_q, active_d;
    logic [3:0]        score_q, score_d;
    logic [NUM_EQ-1:0] eq_start_q, eq_start_d;
    logic [NUM_EQ-1:0] eq_abort_q, eq_abort_d;
    logic              game_over_q, game_over_d;
    logic              busy_q, busy_d;

    logic [NUM_EQ-1:0] active_oh;
    logic [NUM_EQ-1:0] next_oh;
    logic              correct_sel;
    logic              timeout;

    assign active_oh   = ONE << active_q;
    assign next_oh     = ONE << active_d;
    assign correct_sel = |(eq_correct & active_oh);

    round_timer #(
        .TIME_LIMIT(TIME_LIMIT)
    ) u_round_timer (
        .clk    (Clock),
        .rst_n  (Resetn),
        .latch  (state_q == S_START),
        .now    (OngoingTimer),
        .timeout(timeout)
    );

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        score_d  = score_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (StartGame) begin
                    state_d  = S_START;
                    active_d = 3'd0;
                    score_d  = 4'd0;
                end
            end
            S_START:    state_d = S_WAIT_ANS;
            S_WAIT_ANS: begin
                // A correct answer beats a timeout landing in the same cycle.
                if (correct_sel) begin
                    state_d = S_PASS;
                end else if (timeout) begin
                    state_d = S_ABORT;
                end
            end
            S_PASS: begin
                if (score_q < SCORE_MAX) begin
                    score_d = score_q + 4'd1;
                end
                state_d = S_NEXT;
            end
            S_ABORT:    state_d = S_NEXT;
            S_NEXT: begin
                if (active_q == LAST_EQ) begin
                    state_d = S_DONE;
                end else begin
                    active_d = active_q + 3'd1;
                    state_d  = S_START;
                end
            end
            default:    state_d = S_IDLE;
        endcase
    end

    // Pulse outputs are decoded from the next state so they are flops that
    // line up exactly with the START / ABORT / DONE cycles.
    always_comb begin
        eq_start_d  = (state_d == S_START) ? next_oh : '0;
        eq_abort_d  = (state_d == S_ABORT) ? active_oh : '0;
        game_over_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            active_q    <= 3'd0;
            score_q     <= 4'd0;
            eq_start_q  <= '0;
            eq_abort_q  <= '0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            score_q     <= score_d;
            eq_start_q  <= eq_start_d;
            eq_abort_q  <= eq_abort_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;
        end
    end

    assign eq_go     = (state_q == S_WAIT_ANS && Go) ? active_oh : '0;
    assign eq_start  = eq_start_q;
    assign eq_abort  = eq_abort_q;
    assign active_eq = active_q;
    assign score     = score_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_equation_scheduler.sv
// Scenario bench for equation_scheduler: start/abort pulses are checked against
// an expected queue, everything else inline in each scenario task.
module tb_equation_scheduler;
    import mathrix_pkg::*;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start_game;
    logic         go;
    logic [6:0]   ot;
    logic [N-1:0] eq_correct;
    logic [N-1:0] eq_start;
    logic [N-1:0] eq_go;
    logic [N-1:0] eq_abort;
    logic [2:0]   active_eq;
    logic [3:0]   score;
    logic         busy;
    logic         game_over;
    state_t       dbg_state;

    int n_vec;
    int n_err;
    logic [2*N-1:0] exp_q[$];

    equation_scheduler #(
        .NUM_EQ    (N),
        .TIME_LIMIT(7'd30)
    ) dut (
        .Clock       (clk),
        .Resetn      (rst_n),
        .StartGame   (start_game),
        .Go          (go),
        .OngoingTimer(ot),
        .eq_correct  (eq_correct),
        .eq_start    (eq_start),
        .eq_go       (eq_go),
        .eq_abort    (eq_abort),
        .active_eq   (active_eq),
        .score       (score),
        .busy        (busy),
        .game_over   (game_over),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] oh(input int k);
        logic [N-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // scoreboard: every start/abort pulse must match the head of exp_q
    always @(negedge clk) begin
        if (eq_start != '0 || eq_abort != '0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected: got abort=%b start=%b, queue empty", eq_abort, eq_start);
            end else begin
                logic [2*N-1:0] e;
                e = exp_q.pop_front();
                if ({eq_abort, eq_start} !== e) begin
                    n_err++;
                    $display("FAIL pulse: got abort=%b start=%b, want abort=%b start=%b",
                             eq_abort, eq_start, e[2*N-1:N], e[N-1:0]);
                end
            end
        end
    end

    function automatic logic [2*N-1:0] ev_start(input int k);
        return {{N{1'b0}}, oh(k)};
    endfunction

    function automatic logic [2*N-1:0] ev_abort(input int k);
        return {oh(k), {N{1'b0}}};
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        ot = ot + 7'd1;
    endtask

    task automatic wait_start(input int budget);
        for (int i = 0; i < budget && eq_start == '0; i++) step();
        n_vec++;
        if (eq_start == '0) begin
            n_err++;
            $display("FAIL wait_start: no eq_start within %0d cycles", budget);
        end
    endtask

    task automatic begin_game();
        start_game = 1'b1;
        step();
        start_game = 1'b0;
        wait_start(10);
    endtask

    // Caller is in the START cycle of equation k; no answer is ever given.
    task automatic run_timeout(input int k, input logic [6:0] t0, input logic [3:0] sc);
        ot = t0;
        for (int i = 1; i <= 30; i++) begin
            step();
            n_vec++;
            if (dbg_state !== S_WAIT_ANS || eq_abort !== '0) begin
                n_err++;
                $display("FAIL early_abort eq%0d t+%0d: state=%0d abort=%b, want WAIT_ANS abort=0",
                         k, i, dbg_state, eq_abort);
            end
        end
        step();
        n_vec++;
        if (eq_abort !== oh(k) || dbg_state !== S_ABORT) begin
            n_err++;
            $display("FAIL abort_timing eq%0d: abort=%b state=%0d, want %b ABORT", k, eq_abort, dbg_state, oh(k));
        end
        step();
        step();
        n_vec++;
        if (eq_start !== oh(k + 1) || score !== sc) begin
            n_err++;
            $display("FAIL after_abort eq%0d: start=%b score=%0d, want %b %0d", k, eq_start, score, oh(k + 1), sc);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({eq_start, eq_go, eq_abort, active_eq, score, busy, game_over} !== '0 || dbg_state !== S_IDLE) begin
            n_err++;
            $display("FAIL reset_outputs: start=%b go=%b abort=%b act=%0d score=%0d busy=%b over=%b state=%0d, want all 0",
                     eq_start, eq_go, eq_abort, active_eq, score, busy, game_over, dbg_state);
        end
        #3 rst_n = 1'b1;
        repeat (4) step();
        n_vec++;
        if (dbg_state !== S_IDLE || busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: state=%0d busy=%b, want IDLE 0", dbg_state, busy);
        end
    endtask

    task automatic test_all_correct();
        for (int k = 0; k < N; k++) exp_q.push_back(ev_start(k));
        begin_game();
        for (int k = 0; k < N; k++) begin
            repeat (5) step();
            eq_correct = oh(k);
            step();
            eq_correct = '0;
            n_vec++;
            if (score !== 4'(k)) begin
                n_err++;
                $display("FAIL score_n1 eq%0d: got %0d want %0d", k, score, k);
            end
            step();
            n_vec++;
            if (score !== 4'(k + 1)) begin
                n_err++;
                $display("FAIL score_n2 eq%0d: got %0d want %0d", k, score, k + 1);
            end
            step();
            n_vec++;
            if (k < N - 1) begin
                if (eq_start !== oh(k + 1)) begin
                    n_err++;
                    $display("FAIL start_n3 eq%0d: got %b want %b", k, eq_start, oh(k + 1));
                end
            end else if (dbg_state !== S_DONE) begin
                n_err++;
                $display("FAIL done_n3: state=%0d want DONE", dbg_state);
            end
        end
        n_vec++;
        if (score !== 4'd4 || game_over !== 1'b1 || busy !== 1'b0 || active_eq !== 3'd3) begin
            n_err++;
            $display("FAIL all_correct_end: score=%0d over=%b busy=%b act=%0d, want 4 1 0 3",
                     score, game_over, busy, active_eq);
        end
    endtask

    // eq0 times out from 10, eq1 wraps from 120 to 22, eq2 ties, eq3 passes.
    task automatic test_timeout_wrap_tie();
        exp_q.push_back(ev_start(0));
        exp_q.push_back(ev_abort(0));
        exp_q.push_back(ev_start(1));
        exp_q.push_back(ev_abort(1));
        exp_q.push_back(ev_start(2));
        exp_q.push_back(ev_start(3));
        begin_game();
        n_vec++;
        if (score !== 4'd0 || active_eq !== 3'd0) begin
            n_err++;
            $display("FAIL restart_from_done: score=%0d act=%0d, want 0 0", score, active_eq);
        end
        run_timeout(0, 7'd10, 4'd0);
        run_timeout(1, 7'd120, 4'd0);
        ot = 7'd50;
        repeat (30) step();
        eq_correct = oh(2);
        step();
        eq_correct = '0;
        n_vec++;
        if (dbg_state !== S_PASS || eq_abort !== '0) begin
            n_err++;
            $display("FAIL tie: state=%0d abort=%b, want PASS 0", dbg_state, eq_abort);
        end
        step();
        n_vec++;
        if (score !== 4'd1) begin
            n_err++;
            $display("FAIL tie_score: got %0d want 1", score);
        end
        step();
        step();
        eq_correct = oh(3);
        step();
        eq_correct = '0;
        repeat (2) step();
        n_vec++;
        if (score !== 4'd2 || game_over !== 1'b1 || active_eq !== 3'd3) begin
            n_err++;
            $display("FAIL mixed_end: score=%0d over=%b act=%0d, want 2 1 3", score, game_over, active_eq);
        end
    endtask

    task automatic test_routing_and_reset();
        for (int k = 0; k < 3; k++) exp_q.push_back(ev_start(k));
        begin_game();
        step();
        eq_correct = oh(0);
        step();
        eq_correct = '0;
        step();
        step();
        go = 1'b1;
        #1;
        n_vec++;
        if (eq_start !== oh(1) || eq_go !== '0) begin
            n_err++;
            $display("FAIL route_start: start=%b go=%b, want %b 0000", eq_start, eq_go, oh(1));
        end
        step();
        n_vec++;
        if (eq_go !== oh(1)) begin
            n_err++;
            $display("FAIL route_go_hi: got %b want %b", eq_go, oh(1));
        end
        go = 1'b0;
        #1;
        n_vec++;
        if (eq_go !== '0) begin
            n_err++;
            $display("FAIL route_go_lo: got %b want 0000", eq_go);
        end
        go         = 1'b1;
        start_game = 1'b1;
        eq_correct = oh(3) | oh(0);
        step();
        n_vec++;
        if (eq_go !== oh(1) || dbg_state !== S_WAIT_ANS || active_eq !== 3'd1 || score !== 4'd1) begin
            n_err++;
            $display("FAIL route_ignore: go=%b state=%0d act=%0d score=%0d, want %b WAIT_ANS 1 1",
                     eq_go, dbg_state, active_eq, score, oh(1));
        end
        start_game = 1'b0;
        go         = 1'b0;
        eq_correct = oh(1);
        step();
        eq_correct = '0;
        repeat (4) step();
        go = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({eq_start, eq_go, eq_abort, active_eq, score, busy, game_over} !== '0 || dbg_state !== S_IDLE) begin
            n_err++;
            $display("FAIL async_reset: go=%b act=%0d score=%0d busy=%b state=%0d, want all 0",
                     eq_go, active_eq, score, busy, dbg_state);
        end
        go = 1'b0;
        #2 rst_n = 1'b1;
        repeat (3) step();
        n_vec++;
        if (dbg_state !== S_IDLE) begin
            n_err++;
            $display("FAIL reset_idle: state=%0d want IDLE", dbg_state);
        end
        exp_q.push_back(ev_start(0));
        begin_game();
        n_vec++;
        if (score !== 4'd0 || active_eq !== 3'd0 || eq_start !== oh(0)) begin
            n_err++;
            $display("FAIL reset_restart: score=%0d act=%0d start=%b, want 0 0 %b", score, active_eq, eq_start, oh(0));
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start_game = 1'b0;
        go         = 1'b0;
        ot         = 7'd0;
        eq_correct = '0;
        #3;
        test_reset();
        test_all_correct();
        test_timeout_wrap_tie();
        test_routing_and_reset();
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_pulses: %0d expected pulses never seen, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/equation_scheduler.md
EQUATION_SCHEDULER -- requirements
Module: equation_scheduler

Interface
REQ-001 Parameter NUM_EQ, default 4: number of equation blocks sequenced per game (2..8).
REQ-002 Parameter TIME_LIMIT, default 7'd30: per-equation answer budget in OngoingTimer units.
REQ-003 Clock  in  1  system clock; all state changes on the rising edge.
REQ-004 Resetn  in  1  asynchronous, active-low reset.
REQ-005 StartGame  in  1  level; starts a game when sampled high in IDLE or DONE.
REQ-006 Go  in  1  player entry key, shared by all equations.
REQ-007 OngoingTimer  in  7  free-running time count, increments by 1 and wraps 127->0.
REQ-008 eq_correct  in  NUM_EQ  correct flag of each equation block.
REQ-009 eq_start  out  NUM_EQ  one-hot, one-cycle start pulse to the active equation.
REQ-010 eq_go  out  NUM_EQ  Go routed only to the active equation.
REQ-011 eq_abort  out  NUM_EQ  one-hot, one-cycle forced reset of the active equation on timeout.
REQ-012 active_eq  out  3  index of the current equation.
REQ-013 score  out  4  count of equations answered correctly in this game.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 game_over  out  1  high only in DONE.

Function
REQ-016 FSM states: IDLE, START, WAIT_ANS, PASS, ABORT, NEXT, DONE.
REQ-017 IDLE->START when StartGame=1; clear score and active_eq on the same edge.
REQ-018 START: drive eq_start[active_eq]=1 and latch start_time=OngoingTimer; go to WAIT_ANS next cycle.
REQ-019 WAIT_ANS: eq_go = Go ? one-hot(active_eq) : 0; eq_go is 0 in all other states.
REQ-020 WAIT_ANS: compute elapsed=(OngoingTimer-start_time) mod 128; a single wrap is handled correctly.
REQ-021 WAIT_ANS->PASS when eq_correct[active_eq]=1; otherwise ->ABORT when elapsed>=TIME_LIMIT.
REQ-022 If correct and timeout occur in the same cycle, PASS wins.
REQ-023 eq_correct bits of non-active equations are ignored.
REQ-024 PASS: score increments by 1 (saturates at NUM_EQ); go to NEXT.
REQ-025 ABORT: drive eq_abort[active_eq]=1 for exactly one cycle; score is unchanged; go to NEXT.
REQ-026 NEXT: if active_eq==NUM_EQ-1 go to DONE, else increment active_eq and go to START.
REQ-027 DONE: hold score and active_eq; go to START with score=0 and active_eq=0 when StartGame=1.
REQ-028 StartGame is ignored while busy=1.
REQ-029 Latency: eq_correct high in WAIT_ANS at cycle n gives score+1 visible at n+2 and the next eq_start at n+3.
REQ-030 eq_start, eq_abort and game_over are registered outputs, and eq_start and eq_abort are never both non-zero.

Reset
REQ-031 Resetn=0 forces IDLE immediately, independent of Clock, including mid-game.
REQ-032 On reset, every output is 0: eq_start, eq_go, eq_abort, active_eq, score, busy and game_over; start_time is also 0.
REQ-033 After Resetn deasserts, the first transition requires a fresh StartGame.

Structure
REQ-034 Shared package mathrix_pkg holds the state enum, NUM_EQ_DEFAULT and TIME_LIMIT_DEFAULT.
REQ-035 One sub-module, round_timer: it latches start_time and outputs the timeout comparison, elapsed>=TIME_LIMIT with modular subtraction.
REQ-036 Target size is 120-400 lines of RTL, with no multipliers or dividers.

Verification
REQ-037 All-correct: StartGame, then eq_correct[k] pulsed 5 cycles after each eq_start[k] -> score=4, game_over=1, four eq_start pulses in order 0..3, and eq_abort is never asserted.
REQ-038 Timeout: no eq_correct and OngoingTimer stepping each cycle from 10 -> eq_abort[0] fires one cycle after elapsed reaches 30, then eq_start[1] fires, and score stays 0.
REQ-039 Wrap: start_time=120 and OngoingTimer wraps to 22 (elapsed 30) -> timeout occurs exactly there, with no early or late abort.
REQ-040 Tie: eq_correct[2]=1 in the same cycle elapsed reaches TIME_LIMIT -> PASS taken, score increments, and eq_abort stays 0.
REQ-041 Routing: Go pulses while active_eq=1 -> only eq_go[1] toggles, and eq_correct[3]=1 injected then has no effect.
REQ-042 Reset mid-game: Resetn low in WAIT_ANS of equation 2 -> all outputs 0 asynchronously and IDLE; StartGame then restarts from equation 0 with score 0.
